// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: owner codes, request bundle and defaults shared by the data-RAM arbiter
package dmem_arb_pkg;
   localparam logic OWNER_M0 = 1'b0;
   localparam logic OWNER_M1 = 1'b1;
   localparam int STARVE_LIMIT_DEF = 8;
   localparam int AW_DEF = 32;
   localparam int DW_DEF = 32;
   typedef struct packed {
      logic                we;
      logic [AW_DEF-1:0]   addr;
      logic [DW_DEF-1:0]   wdata;
      logic [DW_DEF/8-1:0] wmask;
   } req_t;
endpackage

// File: rtl/arb_starve_guard.sv
// arb_starve_guard: counts consecutive m1 wait cycles and flags that m1 must win the next contended cycle
module arb_starve_guard
   import dmem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic i_m0_valid,
   input  logic i_m1_valid,
   input  logic i_m1_ready,
   output logic o_m1_pri
);
   localparam logic [7:0] LIM = 8'(STARVE_LIMIT);
   logic [7:0] r_cnt;
   always_ff @(posedge clk)
      if (reset || !i_m1_valid || i_m1_ready) r_cnt <= '0;
      else if (r_cnt < LIM) r_cnt <= r_cnt + 8'd1;
   assign o_m1_pri = i_m0_valid & i_m1_valid & (r_cnt >= LIM);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data RAM between the CPU port (m0) and a secondary master (m1)
// with fixed m0 priority, an m1 starvation guard, 1-cycle read return routing and an m0 stall counter
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW           = AW_DEF,
   parameter int DW           = DW_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_valid,
   input  logic              m0_we,
   input  logic [AW-1:0]     m0_addr,
   input  logic [DW-1:0]     m0_wdata,
   input  logic [DW/8-1:0]   m0_wmask,
   output logic              m0_ready,
   output logic              m0_rvalid,
   output logic [DW-1:0]     m0_rdata,
   input  logic              m1_valid,
   input  logic              m1_we,
   input  logic [AW-1:0]     m1_addr,
   input  logic [DW-1:0]     m1_wdata,
   input  logic [DW/8-1:0]   m1_wmask,
   output logic              m1_ready,
   output logic              m1_rvalid,
   output logic [DW-1:0]     m1_rdata,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   output logic [DW/8-1:0]   mem_wmask,
   input  logic [DW-1:0]     mem_rdata,
   output logic [CNT_W-1:0]  stall_cnt
);
   logic w_pri, w_grant;
   req_t w_req;
   logic r_pend, r_owner;
   logic [CNT_W-1:0] r_stall;

   arb_starve_guard #(.STARVE_LIMIT(STARVE_LIMIT)) u_guard (
      .clk        (clk),
      .reset      (reset),
      .i_m0_valid (m0_valid),
      .i_m1_valid (m1_valid),
      .i_m1_ready (m1_ready),
      .o_m1_pri   (w_pri)
   );

   assign m1_ready = ~reset & m1_valid & (~m0_valid | w_pri);
   assign m0_ready = ~reset & m0_valid & ~m1_ready;
   assign w_grant  = m0_ready | m1_ready;
   assign w_req    = m1_ready ? {m1_we, m1_addr, m1_wdata, m1_wmask}
                              : {m0_we, m0_addr, m0_wdata, m0_wmask};

   assign mem_we    = w_grant & w_req.we;
   assign mem_addr  = w_req.addr;
   assign mem_wdata = w_req.wdata;
   assign mem_wmask = w_req.wmask;

   always_ff @(posedge clk)
      if (reset) begin
         r_pend  <= 1'b0;
         r_owner <= OWNER_M0;
         r_stall <= '0;
      end else begin
         r_pend  <= w_grant & ~w_req.we;
         r_owner <= m1_ready ? OWNER_M1 : OWNER_M0;
         if (m0_valid & ~m0_ready) r_stall <= r_stall + CNT_W'(1);
      end

   // gating with reset kills a response whose read was accepted just before reset
   assign m0_rvalid = ~reset & r_pend & (r_owner == OWNER_M0);
   assign m1_rvalid = ~reset & r_pend & (r_owner == OWNER_M1);
   assign m0_rdata  = mem_rdata;
   assign m1_rdata  = mem_rdata;
   assign stall_cnt = r_stall;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized + directed scoreboard bench for dmem_arbiter against a rule-level model
module tb_dmem_arbiter;
   localparam int LIM = 8;

   typedef struct {
      bit          idle;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } op_t;

   typedef struct {
      bit          owner;
      logic [31:0] data;
   } rsp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        m0_valid, m0_we, m1_valid, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_wmask, m1_wmask;
   logic        m0_ready, m0_rvalid, m1_ready, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;
   logic [31:0] stall_cnt;

   int   checks = 0;
   int   failures = 0;
   bit   started = 1'b0;
   op_t  q0[$], q1[$];
   rsp_t expq[$];

   dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
      .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
      .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(int i);
      logic [7:0] b = 8'(i);
      return (i == 16) ? 32'hDEADBEEF : {b, ~b, 8'(i * 3), b ^ 8'h5A};
   endfunction

   function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] m);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h at %0t", n, act, exp, $time);
      end
   endtask

   // RAM with one-cycle registered read
   initial begin
      logic [31:0] ram [64];
      for (int i = 0; i < 64; i++) ram[i] = init_word(i);
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         mem_rdata <= ram[mem_addr[7:2]];
         if (mem_we) ram[mem_addr[7:2]] = merge(ram[mem_addr[7:2]], mem_wdata, mem_wmask);
      end
   end

   // driver: presents queue heads, holding each request until accepted
   initial begin
      m0_valid = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_wmask = 0;
      m1_valid = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_wmask = 0;
      forever begin
         @(posedge clk);
         #2;
         m0_valid = !reset && q0.size() > 0 && !q0[0].idle;
         m1_valid = !reset && q1.size() > 0 && !q1[0].idle;
         if (m0_valid) begin
            m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].wdata; m0_wmask = q0[0].wmask;
         end else begin
            m0_we = 1'($urandom); m0_addr = $urandom; m0_wdata = $urandom; m0_wmask = 4'($urandom);
         end
         if (m1_valid) begin
            m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].wdata; m1_wmask = q1[0].wmask;
         end else begin
            m1_we = 1'($urandom); m1_addr = $urandom; m1_wdata = $urandom; m1_wmask = 4'($urandom);
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (q0.size() > 0 && (q0[0].idle || (m0_valid && m0_ready))) void'(q0.pop_front());
      if (q1.size() > 0 && (q1[0].idle || (m1_valid && m1_ready))) void'(q1.pop_front());
   end

   // reference model: grant rules, memory contents, stall count; pushes expected read responses
   initial begin
      logic [31:0] ref_mem [64];
      logic [31:0] m_stall = 0;
      int          m_wait = 0;
      bit          e0, e1, w;
      logic [31:0] a;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      forever begin
         @(negedge clk);
         if (started) begin
            e1 = !reset && m1_valid && (!m0_valid || m_wait >= LIM);
            e0 = !reset && m0_valid && !e1;
            chk("m0_ready", m0_ready, e0);
            chk("m1_ready", m1_ready, e1);
            chk("stall_cnt", stall_cnt, m_stall);
            if (e0 || e1) begin
               w = e1 ? m1_we : m0_we;
               a = e1 ? m1_addr : m0_addr;
               chk("mem_we", mem_we, w);
               chk("mem_addr", mem_addr, a);
               if (w) begin
                  chk("mem_wdata", mem_wdata, e1 ? m1_wdata : m0_wdata);
                  chk("mem_wmask", mem_wmask, e1 ? m1_wmask : m0_wmask);
                  ref_mem[a[7:2]] = merge(ref_mem[a[7:2]], e1 ? m1_wdata : m0_wdata, e1 ? m1_wmask : m0_wmask);
               end else expq.push_back('{e1, ref_mem[a[7:2]]});
            end else chk("mem_we_idle", mem_we, 0);
            if (reset) begin
               m_wait = 0;
               m_stall = 0;
            end else begin
               if (m0_valid && !e0) m_stall++;
               m_wait = (m1_valid && !e1) ? m_wait + 1 : 0;
            end
         end
      end
   end

   // monitor: every cycle the read-return ports must match the scoreboard head
   initial forever begin
      rsp_t r;
      @(posedge clk);
      #3;
      if (started) begin
         if (reset) begin
            chk("rvalid_in_reset", {m0_rvalid, m1_rvalid}, 0);
            expq.delete();
         end else if (expq.size() > 0) begin
            r = expq.pop_front();
            chk("m0_rvalid", m0_rvalid, !r.owner);
            chk("m1_rvalid", m1_rvalid, r.owner);
            chk(r.owner ? "m1_rdata" : "m0_rdata", r.owner ? m1_rdata : m0_rdata, r.data);
         end else chk("rvalid_idle", {m0_rvalid, m1_rvalid}, 0);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

   function automatic op_t rd(logic [31:0] a);
      return '{0, 0, a, 32'h0, 4'h0};
   endfunction

   function automatic op_t wr(logic [31:0] a, logic [31:0] d, logic [3:0] m);
      return '{0, 1, a, d, m};
   endfunction

   function automatic op_t idl();
      return '{1, 0, 32'h0, 32'h0, 4'h0};
   endfunction

   task automatic wait_idle(int budget);
      for (int i = 0; i < budget && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
      chk("queue_timeout", q0.size() + q1.size(), 0);
   endtask

   initial begin
      @(posedge clk);
      #1 started = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      q1.push_back(rd(32'h40));
      wait_idle(50);
      repeat (3) @(posedge clk);
      for (int i = 0; i < 12; i++) q0.push_back(rd(32'(4 * i)));
      q1.push_back(rd(32'h44));
      wait_idle(100);
      repeat (3) @(posedge clk);
      q0.push_back(wr(32'h80, 32'h12345678, 4'b0011));
      q1.push_back(idl());
      q1.push_back(rd(32'h80));
      wait_idle(50);
      repeat (3) @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         q0.push_back(rd(32'h00)); q0.push_back(idl());
         q1.push_back(idl());      q1.push_back(rd(32'h04));
      end
      wait_idle(100);
      repeat (3) @(posedge clk);
      q0.push_back(rd(32'h10));
      q0.push_back(idl());
      q0.push_back(idl());
      q0.push_back(idl());
      q1.push_back(idl());
      while (q0.size() > 3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #4 chk("stall_post_reset", stall_cnt, 0);
      wait_idle(50);
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) q0.push_back(idl());
         if ($urandom_range(0, 2) == 0) q1.push_back(idl());
         q0.push_back('{0, 1'($urandom), 32'($urandom_range(0, 63) * 4), $urandom, 4'($urandom_range(1, 15))});
         q1.push_back('{0, 1'($urandom), 32'($urandom_range(0, 63) * 4), $urandom, 4'($urandom_range(1, 15))});
      end
      wait_idle(20000);
      repeat (4) @(posedge clk);
      chk("expq_drained", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
